// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : layer_compositor
// Purpose  : N-layer sprite/background pixel compositor with a fixed 2-cycle
//            pipeline. Layer 0 has the highest priority. Supports an opaque
//            priority mode and a 50% blend of the top two surfaces. Layer
//            enables take effect only on frame boundaries. Per-frame sprite
//            collisions are reported at each rising edge of vertical sync.
// Ports    : i_clk, i_rst_n          clock, asynchronous active-low reset
//            i_pix_valid             input pixel valid
//            i_v_sync                vertical sync (rising edge = frame edge)
//            i_layer_hit/rgb         per-layer hit flags and {R,G,B} colours
//            i_bg_rgb                background {R,G,B}
//            i_layer_en              requested layer enables (frame-sampled)
//            i_blend_mode            0 = opaque priority, 1 = 50% blend
//            o_red/o_green/o_blue    composited pixel
//            o_valid                 output pixel valid (2 cycles after input)
//            o_collide_mask          layers that collided in previous frame
//            o_frame_done            one-cycle pulse when the mask updates
// Revision : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int N_LAYERS = 4,
    parameter int CW       = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_pix_valid,
    input  logic                       i_v_sync,
    input  logic [N_LAYERS-1:0]        i_layer_hit,
    input  logic [N_LAYERS*3*CW-1:0]   i_layer_rgb,
    input  logic [3*CW-1:0]            i_bg_rgb,
    input  logic [N_LAYERS-1:0]        i_layer_en,
    input  logic                       i_blend_mode,
    output logic [CW-1:0]              o_red,
    output logic [CW-1:0]              o_green,
    output logic [CW-1:0]              o_blue,
    output logic                       o_valid,
    output logic [N_LAYERS-1:0]        o_collide_mask,
    output logic                       o_frame_done
);

    localparam int c_PW = 3 * CW;   // width of one packed {R,G,B} pixel

    // ------------------------------------------------------------------
    // Frame boundary detection and frame-synchronous state
    // ------------------------------------------------------------------
    logic                  r_vs_q;
    logic                  w_frame_edge;
    logic [N_LAYERS-1:0]   r_en_act;
    logic [N_LAYERS-1:0]   r_acc;
    logic [N_LAYERS-1:0]   w_coll_now;

    assign w_frame_edge = i_v_sync & ~r_vs_q;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                         r_s1_valid;
    logic [N_LAYERS-1:0]          r_s1_hit;
    logic [N_LAYERS*c_PW-1:0]     r_s1_rgb;
    logic [c_PW-1:0]              r_s1_bg;
    logic                         r_s1_mode;

    // ------------------------------------------------------------------
    // Stage 2 selection: top surface and the one directly beneath it.
    // When fewer than two layers hit, the missing surface is background.
    // ------------------------------------------------------------------
    logic [c_PW-1:0]  w_top_rgb;
    logic [c_PW-1:0]  w_sec_rgb;
    logic             w_any_hit;
    logic             w_multi_hit;

    always_comb begin
        w_top_rgb   = r_s1_bg;
        w_sec_rgb   = r_s1_bg;
        w_any_hit   = 1'b0;
        w_multi_hit = 1'b0;
        for (int k = 0; k < N_LAYERS; k++) begin
            if (r_s1_hit[k]) begin
                if (!w_any_hit) begin
                    w_top_rgb = r_s1_rgb[k*c_PW +: c_PW];
                    w_any_hit = 1'b1;
                end else if (!w_multi_hit) begin
                    w_sec_rgb   = r_s1_rgb[k*c_PW +: c_PW];
                    w_multi_hit = 1'b1;
                end
            end
        end
    end

    // Two or more enabled hits on a valid pixel means every hit layer collides.
    assign w_coll_now = {N_LAYERS{r_s1_valid & w_multi_hit}} & r_s1_hit;

    // Per-channel average; the sum carries one extra bit so the result is
    // the floor of the true mean with no wrap-around.
    logic [c_PW-1:0] w_avg_rgb;

    for (genvar c = 0; c < 3; c++) begin : g_chan
        logic [CW:0] w_sum;
        assign w_sum = {1'b0, w_top_rgb[c*CW +: CW]} + {1'b0, w_sec_rgb[c*CW +: CW]};
        assign w_avg_rgb[c*CW +: CW] = w_sum[CW:1];
    end

    logic [c_PW-1:0] w_pix_rgb;

    always_comb begin
        w_pix_rgb = r_s1_bg;
        if (w_any_hit) begin
            w_pix_rgb = r_s1_mode ? w_avg_rgb : w_top_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_q         <= 1'b0;
            r_en_act       <= {N_LAYERS{1'b1}};
            r_acc          <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_hit       <= '0;
            r_s1_rgb       <= '0;
            r_s1_bg        <= '0;
            r_s1_mode      <= 1'b0;
            o_red          <= '0;
            o_green        <= '0;
            o_blue         <= '0;
            o_valid        <= 1'b0;
            o_collide_mask <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            r_vs_q <= i_v_sync;

            // Stage 1: masking uses the enables in force before any update
            // happening on this same edge.
            r_s1_valid <= i_pix_valid;
            r_s1_hit   <= i_layer_hit & r_en_act;
            r_s1_rgb   <= i_layer_rgb;
            r_s1_bg    <= i_bg_rgb;
            r_s1_mode  <= i_blend_mode;

            // Stage 2
            o_valid <= r_s1_valid;
            o_red   <= w_pix_rgb[2*CW +: CW];
            o_green <= w_pix_rgb[1*CW +: CW];
            o_blue  <= w_pix_rgb[0*CW +: CW];

            // A collision seen on the boundary cycle belongs to the frame
            // that is ending, so it is folded into the reported mask.
            if (w_frame_edge) begin
                r_en_act       <= i_layer_en;
                o_collide_mask <= r_acc | w_coll_now;
                r_acc          <= '0;
                o_frame_done   <= 1'b1;
            end else begin
                r_acc          <= r_acc | w_coll_now;
                o_frame_done   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer pixel compositor. Replaces the fixed two-sprite, combinational priority mux in the gfx top level.
- Takes per-layer RGB and hit flags plus background RGB. Produces registered output pixel with fixed 2-cycle latency.
- Adds per-layer enables that switch only on frame boundaries, an optional 50% blend mode, and per-frame sprite collision reporting latched at vertical sync.

Parameters:
- N_LAYERS, 4, number of sprite layers; index 0 has highest priority. Legal range 2..8.
- CW, 8, bits per colour channel.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_valid  in  1  input pixel data valid this cycle
- i_v_sync  in  1  vertical sync; rising edge marks frame boundary
- i_layer_hit  in  N_LAYERS  per-layer hit flag; bit k = layer k
- i_layer_rgb  in  N_LAYERS*3*CW  per-layer colour; layer k at bits [k*3*CW +: 3*CW], ordered {R,G,B}, R in MSBs
- i_bg_rgb  in  3*CW  background colour {R,G,B}
- i_layer_en  in  N_LAYERS  requested layer enables; sampled at frame boundary
- i_blend_mode  in  1  0 = opaque priority, 1 = average of top two surfaces
- o_red / o_green / o_blue  out  CW each  composited pixel
- o_valid  out  1  output pixel valid
- o_collide_mask  out  N_LAYERS  layers that overlapped another layer during the previous frame
- o_frame_done  out  1  one-cycle pulse when o_collide_mask updates

Behaviour:

Reset (i_rst_n low, asynchronous):
- All outputs 0.
- Pipeline registers 0.
- v_sync edge register 0; collision accumulator 0.
- Active-enable register en_act = all ones.

Frame boundary:
- frame_edge = i_v_sync & ~vs_q, where vs_q is i_v_sync registered.
- On frame_edge:
  - en_act <= i_layer_en.
  - o_collide_mask <= acc | coll_now, where coll_now is the stage-2 collision vector of this cycle.
  - acc <= 0.
  - o_frame_done <= 1 for exactly one cycle.
- Otherwise: acc <= acc | coll_now.
- i_layer_en changes mid-frame have no effect until the next frame_edge.

Stage 1 (registered):
- s1_valid <= i_pix_valid.
- s1_hit <= i_layer_hit & en_act, using en_act as it stands before any same-cycle update.
- s1_rgb <= i_layer_rgb; s1_bg <= i_bg_rgb; s1_mode <= i_blend_mode.
- All captured unconditionally, independent of valid.

Stage 2 (registered to outputs):
- top = lowest index k with s1_hit[k].
- second = next lowest hit index above top. If none, second is the background.
- No hit: output = s1_bg, regardless of mode.
- mode 0: output = top layer colour.
- mode 1: each channel = (top + second) >> 1. Sum computed at CW+1 bits, truncated (floor).
- o_valid <= s1_valid. Colour outputs update every cycle.
- Total latency i_pix_valid to o_valid: 2 cycles. Throughput: 1 pixel/cycle, no stalls.

Collision:
- coll_now[k] = s1_valid & s1_hit[k] & (popcount(s1_hit) >= 2).
- Disabled layers can never collide or appear in the output.

Boundary conditions:
- frame_edge with s1_valid high: that pixel's collisions go into the reported mask, not the next frame.
- v_sync held high: single edge only.
- Reset mid-frame: clears pending collisions; en_act returns to all ones.

Test Plan:
- N_LAYERS=4. Hits 0b0110, layer1 = {10,20,30}, layer2 = {50,60,70}, mode 0, valid pulse -> two cycles later o_valid=1 and RGB = {10,20,30}. Same with mode 1 -> {30,40,50}.
- Hits 0b0000, bg = {255,0,128}, mode 1 -> output {255,0,128}. Single hit 0b1000, layer3 = {1,3,5}, bg = {2,4,7}, mode 1 -> {1,3,6}.
- After reset, i_layer_en = 0b1110 mid-frame and hits 0b0011 -> layer0 still shown. After a v_sync rising edge, the same hits -> layer1 shown and no collision counted.
- Overlapping hits 0b0101 on 3 valid pixels, then v_sync rising -> o_frame_done one cycle, o_collide_mask = 0b0101. Next frame with no overlaps -> mask 0b0000 at the next edge.
- Overlapping pixel arriving in stage 2 on the same cycle as frame_edge -> included in the reported mask; acc for the new frame = 0.
- Assert i_rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge. en_act = all ones after release.
